// File: rtl/input_conditioner_pkg.sv
// Shared lab constants: debounce timing, counter sizing and stopwatch FSM encodings.
// Imported by the input conditioner and the stopwatch control logic.
package input_conditioner_pkg;

  // 5 ms at 100 MHz
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int DEBOUNCE_CYCLES_MAX     = 1 << 20;

  // Mismatch counter width; the extra bit keeps DEBOUNCE_CYCLES=1 at a legal 1-bit width.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

  typedef enum logic [1:0] {
    SW_IDLE   = 2'b00,
    SW_RUN    = 2'b01,
    SW_PAUSED = 2'b10,
    SW_ADJUST = 2'b11
  } sw_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One conditioned input: two-flop synchronizer, consecutive-mismatch debouncer,
// and either a rising-edge pulse (buttons) or the debounced level (switches).
module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit EDGE_PULSE      = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic out
);

  localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_ZERO = CW'(1'b0);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1'b1);

  logic          sync1_r;
  logic          sync2_r;
  logic          d_r;
  logic [CW-1:0] cnt_r;

  // Metastability synchronizer for the raw asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
    end
  end

  // Debounced value moves only after DEBOUNCE_CYCLES consecutive mismatching edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_r   <= 1'b0;
      cnt_r <= CNT_ZERO;
    end else if (sync2_r == d_r) begin
      d_r   <= d_r;
      cnt_r <= CNT_ZERO;
    end else if (cnt_r == CNT_LAST) begin
      d_r   <= sync2_r;
      cnt_r <= CNT_ZERO;
    end else begin
      d_r   <= d_r;
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  generate
    if (EDGE_PULSE) begin : g_pulse
      logic d_q_r;

      // Previous debounced value, for rising-edge detection.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          d_q_r <= 1'b0;
        end else begin
          d_q_r <= d_r;
        end
      end

      assign out = d_r & ~d_q_r;
    end else begin : g_level
      assign out = d_r;
    end
  endgenerate

endmodule

// File: rtl/input_conditioner.sv
// Conditions the stopwatch pushbuttons and slide switches into clean, synchronous
// control signals; every output is derived from registered state only.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_pause,
  input  logic btn_reset,
  input  logic sw_adj,
  input  logic sw_sel,
  output logic PAUSE,
  output logic RESET,
  output logic ADJ,
  output logic SEL
);

  // Channels are independent; simultaneous presses pulse together and the FSM arbitrates.
  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .EDGE_PULSE      (1'b1)
  ) u_pause (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_pause),
    .out   (PAUSE)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .EDGE_PULSE      (1'b1)
  ) u_reset (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_reset),
    .out   (RESET)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .EDGE_PULSE      (1'b0)
  ) u_adj (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (sw_adj),
    .out   (ADJ)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .EDGE_PULSE      (1'b0)
  ) u_sel (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (sw_sel),
    .out   (SEL)
  );

endmodule
